// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default widths, FSM encoding
// and two's-complement sign helpers also used by the multiplier.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    // abs(0x80000000) stays 0x80000000, which reads correctly as unsigned 2^31.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic           ge;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign ge       = shifted >= {1'b0, divisor};
    // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
    assign next_rem = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: Lo = quotient (truncated toward zero),
// Hi = remainder (sign of dividend), divide-by-zero flagged with done.
//
// state | meaning
// IDLE  | waiting for divControl; Hi/Lo hold the last result
// CALC  | one restoring step per clock, WIDTH steps
// FIX   | apply signs and write Hi/Lo, pulse done
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    div_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sa, sa_n, sb, sb_n;
    logic [WIDTH-1:0] rem, rem_n, quo, quo_n, dvsr, dvsr_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n, dz_n;
    logic [WIDTH-1:0] rem_step, quo_step;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .next_rem (rem_step),
        .next_quo (quo_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            Hi      <= '0;
            Lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sa      <= sa_n;
            sb      <= sb_n;
            rem     <= rem_n;
            quo     <= quo_n;
            dvsr    <= dvsr_n;
            Hi      <= hi_n;
            Lo      <= lo_n;
            busy    <= busy_n;
            done    <= done_n;
            divZero <= dz_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sa_n    = sa;
        sb_n    = sb;
        rem_n   = rem;
        quo_n   = quo;
        dvsr_n  = dvsr;
        hi_n    = Hi;
        lo_n    = Lo;
        busy_n  = busy;
        done_n  = 1'b0;
        dz_n    = 1'b0;

        // A start strobe wins in every state, so a busy divider simply restarts.
        if (divControl) begin
            if (b == '0) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                dz_n    = 1'b1;
            end else begin
                sa_n    = a[WIDTH-1];
                sb_n    = b[WIDTH-1];
                quo_n   = abs_val(a);
                dvsr_n  = abs_val(b);
                rem_n   = '0;
                cnt_n   = CNT_W'(WIDTH);
                busy_n  = 1'b1;
                state_n = CALC;
            end
        end else begin
            case (state)
                CALC: begin
                    rem_n = rem_step;
                    quo_n = quo_step;
                    cnt_n = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_n = FIX;
                end
                FIX: begin
                    lo_n    = (sa ^ sb) ? twos_neg(quo) : quo;
                    hi_n    = sa ? twos_neg(rem) : rem;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against a 64-bit arithmetic model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        divControl;
    logic [31:0] a, b;
    logic [31:0] Hi, Lo;
    logic        busy, done, divZero;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    seq_divider dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .a          (a),
        .b          (b),
        .Hi         (Hi),
        .Lo         (Lo),
        .busy       (busy),
        .done       (done),
        .divZero    (divZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Signed division done in 64 bits so that -2^31 / -1 is representable.
    task automatic model(input logic [31:0] da, input logic [31:0] db,
                         output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        la = longint'($signed(da));
        lb = longint'($signed(db));
        lq = la / lb;
        lr = la % lb;
        q  = lq[31:0];
        r  = lr[31:0];
    endtask

    task automatic start_div(input logic [31:0] da, input logic [31:0] db);
        @(negedge clk);
        divControl = 1'b1;
        a = da;
        b = db;
        @(posedge clk);
        #1;
        divControl = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Returns clocks from the start edge until done is seen; 0 on timeout.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    task automatic run_div(input logic [31:0] da, input logic [31:0] db, input string tag);
        logic [31:0] q, r;
        int lat, bc;
        start_div(da, db);
        if (db == 32'd0) begin
            chk({tag, " dz_done"}, 32'(done), 32'd1);
            chk({tag, " dz_flag"}, 32'(divZero), 32'd1);
            chk({tag, " dz_busy"}, 32'(busy), 32'd0);
            chk({tag, " dz_hi"}, Hi, exp_hi);
            chk({tag, " dz_lo"}, Lo, exp_lo);
        end else begin
            model(da, db, q, r);
            chk({tag, " busy_start"}, 32'(busy), 32'd1);
            chk({tag, " lo_hold"}, Lo, exp_lo);
            wait_done(lat, bc);
            chk({tag, " latency"}, 32'(lat), 32'd33);
            chk({tag, " busy_cycles"}, 32'(bc), 32'd33);
            chk({tag, " lo"}, Lo, q);
            chk({tag, " hi"}, Hi, r);
            chk({tag, " divzero"}, 32'(divZero), 32'd0);
            chk({tag, " busy_end"}, 32'(busy), 32'd0);
            exp_lo = q;
            exp_hi = r;
        end
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, ra, rb;
        int lat, bc, pulses;

        reset = 1'b1;
        divControl = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst hi", Hi, 32'd0);
        chk("rst lo", Lo, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dz", 32'(divZero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div(32'd100, 32'd7, "d100_7");
        run_div(32'hFFFF_FFF9, 32'd2, "dm7_2");
        run_div(32'd7, 32'hFFFF_FFFE, "d7_m2");
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, "dm7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, "ovf");
        run_div(32'd100, 32'd7, "d100_7b");
        run_div(32'd5, 32'd0, "div0");
        chk("div0 kept lo", Lo, 32'd14);
        chk("div0 kept hi", Hi, 32'd2);

        // Restart mid-calculation
        start_div(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        start_div(32'd9, 32'd4);
        wait_done(lat, bc);
        chk("restart latency", 32'(lat), 32'd33);
        chk("restart lo", Lo, 32'd2);
        chk("restart hi", Hi, 32'd1);
        exp_lo = 32'd2;
        exp_hi = 32'd1;
        count_done(40, pulses);
        chk("restart extra done", 32'(pulses), 32'd0);

        // Restart into divide-by-zero while busy
        start_div(32'd100, 32'd7);
        repeat (5) @(posedge clk);
        start_div(32'd5, 32'd0);
        chk("busy dz done", 32'(done), 32'd1);
        chk("busy dz flag", 32'(divZero), 32'd1);
        chk("busy dz busy", 32'(busy), 32'd0);
        chk("busy dz lo", Lo, exp_lo);
        count_done(40, pulses);
        chk("busy dz extra done", 32'(pulses), 32'd0);

        // Start held for three edges: only the last operands count
        @(negedge clk);
        divControl = 1'b1;
        a = 32'd1000;
        b = 32'd3;
        @(negedge clk);
        a = 32'd77;
        b = 32'd5;
        @(negedge clk);
        a = 32'hFFFF_FFCE;
        b = 32'd6;
        @(posedge clk);
        #1;
        divControl = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(lat, bc);
        chk("hold latency", 32'(lat), 32'd33);
        chk("hold lo", Lo, 32'hFFFF_FFF8);
        chk("hold hi", Hi, 32'hFFFF_FFFE);
        exp_lo = Lo;
        exp_hi = Hi;

        // Asynchronous reset in the middle of a division
        run_div(32'd100, 32'd7, "pre_rst");
        start_div(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async rst hi", Hi, 32'd0);
        chk("async rst lo", Lo, 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        count_done(40, pulses);
        chk("async rst no done", 32'(pulses), 32'd0);

        // Randomised operands
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: begin
                    rb = 32'hFFFF_FFFF;
                    ra = 32'h8000_0000;
                end
                default: rb = $urandom;
            endcase
            if (ra[0] && i[1]) ra = ra >> $urandom_range(8, 28);
            run_div(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit integer divider; the inverse operation of the datapath's sequential multiplier.
- Sits in the ALU/HI-LO datapath and is launched by the control unit for DIV.
- Writes the MIPS-convention results: Lo = quotient, Hi = remainder.
- Division truncates toward zero; the remainder takes the sign of the dividend.
- Reports divide-by-zero so the control unit can raise its exception.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- divControl  in  1  start strobe, sampled on the rising edge of clk.
- a  in  WIDTH  dividend, two's complement; sampled only on the start edge.
- b  in  WIDTH  divisor, two's complement; sampled only on the start edge.
- Hi  out  WIDTH  remainder register.
- Lo  out  WIDTH  quotient register.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when Hi/Lo have been updated or divide-by-zero is reported.
- divZero  out  1  one-cycle pulse, coincident with done, when b == 0.

Behaviour:
- Reset (asynchronous, any state): Hi=0, Lo=0, busy=0, done=0, divZero=0, state=IDLE, counter=0, internal registers=0.
- States:
  - IDLE.
  - CALC.
  - FIX.
- Defaults: done and divZero are low every cycle unless set below.
- IDLE, divControl=1 (start edge E0):
  - b != 0:
    - latch sa=a[31], sb=b[31], |a| into the quotient shift register, |b| into the divisor register.
    - clear the partial remainder.
    - counter=WIDTH, busy=1, go to CALC.
  - b == 0:
    - stay in IDLE; Hi/Lo unchanged.
    - done=1 and divZero=1, visible for the cycle after E0.
- CALC, one restoring step per cycle:
  - {rem,quo} shifted left 1 (rem is WIDTH+1 bits).
  - trial = rem - divisor.
  - trial non-negative: rem=trial, quo[0]=1; otherwise quo[0]=0.
  - counter decrements; when it reaches 0, go to FIX.
  - Steps occur on edges E1..E32.
- FIX (edge E33):
  - Lo = (sa^sb) ? -quo : quo.
  - Hi = sa ? -rem : rem.
  - busy=0, done=1, go to IDLE.
- Latency: done is high during the cycle following E33, i.e. 33 clocks after the start edge. Hi/Lo are valid from that cycle and hold until the next completed division or reset.
- Hi/Lo are not modified during CALC; they retain the previous result.
- Overflow case: 0x80000000 / 0xFFFFFFFF produces Lo=0x80000000, Hi=0. This falls out of magnitude arithmetic (|a| = 2^31 fits unsigned). No flag is raised.
- divControl while busy (CALC or FIX): abort the current operation and restart with the new a/b exactly as from IDLE, including the divZero path. The aborted result is never written and done is not pulsed for it.
- divControl held high for several cycles: each sampled edge restarts; the result is produced 33 clocks after the last start edge.
- a and b may change freely after the start edge without affecting the result.
- Reset asserted mid-operation: the operation is discarded, outputs go to reset values, and no done pulse is produced.

Decomposition:
- Shared package div_pkg:
  - WIDTH and CNT_W defaults.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - A two's-complement abs/negate function, shared with the multiplier's sign handling.
- One natural sub-module, div_restore_step: purely combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once by the FSM; it can be unit-tested exhaustively at reduced WIDTH.

Test Plan:
- a=100, b=7, single-cycle start: busy high for 33 cycles; done pulses at the 33rd cycle after start; Lo=14, Hi=2; divZero=0.
- a=-7 (0xFFFFFFF9), b=2: Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- a=7, b=-2: Lo=0xFFFFFFFD, Hi=1.
- a=-7, b=-2: Lo=3, Hi=0xFFFFFFFF.
- a=0x80000000, b=0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Previous result present (Lo=14, Hi=2), then start with a=5, b=0:
  - the next cycle shows done=1 and divZero=1.
  - Hi=2 and Lo=14 remain unchanged; busy stays 0.
- Start 100/7, then assert reset asynchronously (mid-clock) during iteration 10:
  - outputs go to 0 immediately, without waiting for an edge.
  - no done pulse follows.
- Start 100/7, then restart with 9/4 at iteration 10:
  - a single done pulse, 33 cycles after the second start.
  - Lo=2, Hi=1.
